// File: rtl/rng_commit_gen.sv
`default_nettype none
// ============================================================================
// Module   : rng_commit_gen
// Brief    : Seeded xorshift32 pseudo-random generator that emits up to two
//            register-write commits (address, data, enable) every clock.
//            A second commit that hits the same masked address as the first
//            is suppressed, so each address appears at most once per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rng_commit_gen #(
    parameter int          DPI_WIDTH   = 32,
    parameter int          KEY_WIDTH   = 64,
    parameter int          VALUE_WIDTH = 128,
    parameter int          ADDR_BITS   = 5,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [KEY_WIDTH-1:0]   last_wa1_o,
    output logic [VALUE_WIDTH-1:0] last_wd1_o,
    output logic                   last_we1_o,
    output logic [KEY_WIDTH-1:0]   last_wa2_o,
    output logic [VALUE_WIDTH-1:0] last_wd2_o,
    output logic                   last_we2_o
);

    localparam int C_KC = KEY_WIDTH / DPI_WIDTH;
    localparam int C_VC = VALUE_WIDTH / DPI_WIDTH;
    localparam int C_M  = 1 + 2 * C_KC + 2 * C_VC;

    // A zero seed would lock xorshift at zero forever, so it is replaced by 1.
    localparam logic [DPI_WIDTH-1:0] C_SEED_EFF =
        (SEED == 32'h0) ? DPI_WIDTH'(1) : DPI_WIDTH'(SEED);

    localparam logic [KEY_WIDTH-1:0] C_ADDR_MASK =
        {KEY_WIDTH{1'b1}} >> (KEY_WIDTH - ADDR_BITS);

    // Word offsets inside the per-cycle word chain.
    localparam int C_OFS_WA1 = 1;
    localparam int C_OFS_WD1 = C_OFS_WA1 + C_KC;
    localparam int C_OFS_WA2 = C_OFS_WD1 + C_VC;
    localparam int C_OFS_WD2 = C_OFS_WA2 + C_KC;

    function automatic logic [DPI_WIDTH-1:0] xs(input logic [DPI_WIDTH-1:0] x);
        logic [DPI_WIDTH-1:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    logic [DPI_WIDTH-1:0]   s_q, s_d;
    logic [DPI_WIDTH-1:0]   w_words [C_M];
    logic [KEY_WIDTH-1:0]   w_raw_wa1, w_raw_wa2;
    logic [VALUE_WIDTH-1:0] w_raw_wd1, w_raw_wd2;
    logic [DPI_WIDTH-3:0]   enable_bits_unused;

    logic [KEY_WIDTH-1:0]   wa1_q, wa1_d, wa2_q, wa2_d;
    logic [VALUE_WIDTH-1:0] wd1_q, wd1_d, wd2_q, wd2_d;
    logic                   we1_q, we1_d, we2_q, we2_d;

    // Chain of M successive xorshift steps starting from the current state.
    assign w_words[0] = xs(s_q);
    generate
        for (genvar k = 1; k < C_M; k++) begin : g_chain
            assign w_words[k] = xs(w_words[k-1]);
        end
        // Scatter chunks into the wide fields, first chunk least significant.
        for (genvar j = 0; j < C_KC; j++) begin : g_key
            assign w_raw_wa1[j*DPI_WIDTH +: DPI_WIDTH] = w_words[C_OFS_WA1 + j];
            assign w_raw_wa2[j*DPI_WIDTH +: DPI_WIDTH] = w_words[C_OFS_WA2 + j];
        end
        for (genvar j = 0; j < C_VC; j++) begin : g_val
            assign w_raw_wd1[j*DPI_WIDTH +: DPI_WIDTH] = w_words[C_OFS_WD1 + j];
            assign w_raw_wd2[j*DPI_WIDTH +: DPI_WIDTH] = w_words[C_OFS_WD2 + j];
        end
    endgenerate

    // Only the two low bits of the enable word carry meaning.
    assign enable_bits_unused = w_words[0][DPI_WIDTH-1:2];

    // Next-state: mask addresses, zero disabled ports, drop a colliding port 2.
    always_comb begin
        logic [KEY_WIDTH-1:0] m_wa1;
        logic [KEY_WIDTH-1:0] m_wa2;
        logic                 raw_we1;
        logic                 raw_we2;
        m_wa1   = w_raw_wa1 & C_ADDR_MASK;
        m_wa2   = w_raw_wa2 & C_ADDR_MASK;
        raw_we1 = w_words[0][0];
        raw_we2 = w_words[0][1];

        s_d   = w_words[C_M-1];
        we1_d = raw_we1;
        we2_d = raw_we2 & ~(raw_we1 & (m_wa1 == m_wa2));
        wa1_d = we1_d ? m_wa1     : '0;
        wd1_d = we1_d ? w_raw_wd1 : '0;
        wa2_d = we2_d ? m_wa2     : '0;
        wd2_d = we2_d ? w_raw_wd2 : '0;
    end

    // State and registered commit outputs; reset restarts the sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q   <= C_SEED_EFF;
            we1_q <= 1'b0;
            wa1_q <= '0;
            wd1_q <= '0;
            we2_q <= 1'b0;
            wa2_q <= '0;
            wd2_q <= '0;
        end else begin
            s_q   <= s_d;
            we1_q <= we1_d;
            wa1_q <= wa1_d;
            wd1_q <= wd1_d;
            we2_q <= we2_d;
            wa2_q <= wa2_d;
            wd2_q <= wd2_d;
        end
    end

    assign last_we1_o = we1_q;
    assign last_wa1_o = wa1_q;
    assign last_wd1_o = wd1_q;
    assign last_we2_o = we2_q;
    assign last_wa2_o = wa2_q;
    assign last_wd2_o = wd2_q;

endmodule
`default_nettype wire

// File: tb/tb_rng_commit_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_commit_gen
// Brief    : Scoreboard bench for rng_commit_gen. Three instances share clock
//            and reset: defaults (A), ADDR_BITS=1 for collisions (B) and
//            SEED=0 (C, expected to match A).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rng_commit_gen;

    typedef struct {
        logic         we1;
        logic [63:0]  wa1;
        logic [127:0] wd1;
        logic         we2;
        logic [63:0]  wa2;
        logic [127:0] wd2;
    } commit_t;

    typedef struct {
        commit_t a;
        commit_t b;
        int      tag;   // 1 = first batch after any reset
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [63:0]  wa1_a, wa2_a, wa1_b, wa2_b, wa1_c, wa2_c;
    logic [127:0] wd1_a, wd2_a, wd1_b, wd2_b, wd1_c, wd2_c;
    logic         we1_a, we2_a, we1_b, we2_b, we1_c, we2_c;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    rng_commit_gen u_a (
        .clk_i(clk), .rst_i(rst),
        .last_wa1_o(wa1_a), .last_wd1_o(wd1_a), .last_we1_o(we1_a),
        .last_wa2_o(wa2_a), .last_wd2_o(wd2_a), .last_we2_o(we2_a)
    );

    rng_commit_gen #(.ADDR_BITS(1)) u_b (
        .clk_i(clk), .rst_i(rst),
        .last_wa1_o(wa1_b), .last_wd1_o(wd1_b), .last_we1_o(we1_b),
        .last_wa2_o(wa2_b), .last_wd2_o(wd2_b), .last_we2_o(we2_b)
    );

    rng_commit_gen #(.SEED(32'h0)) u_c (
        .clk_i(clk), .rst_i(rst),
        .last_wa1_o(wa1_c), .last_wd1_o(wd1_c), .last_we1_o(we1_c),
        .last_wa2_o(wa2_c), .last_wd2_o(wd2_c), .last_we2_o(we2_c)
    );

    function automatic logic [31:0] xs_ref(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Build one commit pair from the 13 words with a given address width.
    function automatic commit_t make_commit(input logic [31:0] w[13], input int abits);
        commit_t     c;
        logic [63:0] mask, a1, a2;
        logic        e1, e2;
        mask = (64'h1 << abits) - 64'h1;
        a1 = {w[2], w[1]} & mask;
        a2 = {w[8], w[7]} & mask;
        e1 = w[0][0];
        e2 = w[0][1];
        if (e1 && e2 && a1 == a2) e2 = 1'b0;
        c.we1 = e1;
        c.wa1 = e1 ? a1 : 64'h0;
        c.wd1 = e1 ? {w[6], w[5], w[4], w[3]} : 128'h0;
        c.we2 = e2;
        c.wa2 = e2 ? a2 : 64'h0;
        c.wd2 = e2 ? {w[12], w[11], w[10], w[9]} : 128'h0;
        return c;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stimulus + reference model: decide reset for the coming edge, push expectation.
    initial begin : driver
        logic [31:0] s;
        logic [31:0] w[13];
        logic [31:0] x;
        exp_t        e;
        bit          after_rst;
        commit_t     zero;
        zero = '{1'b0, 64'h0, 128'h0, 1'b0, 64'h0, 128'h0};
        s = 32'h1;
        after_rst = 1'b0;
        for (int cyc = 0; cyc < 1045; cyc++) begin
            @(negedge clk);
            rst = (cyc < 3) || (cyc == 37);
            if (rst) begin
                s = 32'h1;
                e.a = zero;
                e.b = zero;
                e.tag = 0;
                after_rst = 1'b1;
            end else begin
                x = s;
                for (int k = 0; k < 13; k++) begin
                    x = xs_ref(x);
                    w[k] = x;
                end
                s = w[12];
                e.a = make_commit(w, 5);
                e.b = make_commit(w, 1);
                e.tag = after_rst ? 1 : 0;
                after_rst = 1'b0;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 128'(sb.size()), 128'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Monitor: every edge the DUTs present a batch; pop and compare.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("A_we1", 128'(we1_a), 128'(e.a.we1));
                chk("A_wa1", 128'(wa1_a), 128'(e.a.wa1));
                chk("A_wd1", wd1_a, e.a.wd1);
                chk("A_we2", 128'(we2_a), 128'(e.a.we2));
                chk("A_wa2", 128'(wa2_a), 128'(e.a.wa2));
                chk("A_wd2", wd2_a, e.a.wd2);
                chk("A_wa1_upper", 128'(wa1_a >> 5), 128'h0);
                chk("A_wa2_upper", 128'(wa2_a >> 5), 128'h0);
                chk("B_we1", 128'(we1_b), 128'(e.b.we1));
                chk("B_wa1", 128'(wa1_b), 128'(e.b.wa1));
                chk("B_wd1", wd1_b, e.b.wd1);
                chk("B_we2", 128'(we2_b), 128'(e.b.we2));
                chk("B_wa2", 128'(wa2_b), 128'(e.b.wa2));
                chk("B_wd2", wd2_b, e.b.wd2);
                if (we1_b && we2_b) begin
                    tests++;
                    if (wa1_b == wa2_b) begin
                        fails++;
                        $display("FAIL B_no_dup_addr: both enabled at address %h", wa1_b);
                    end
                end
                chk("C_we1", 128'(we1_c), 128'(e.a.we1));
                chk("C_wa1", 128'(wa1_c), 128'(e.a.wa1));
                chk("C_wd1", wd1_c, e.a.wd1);
                chk("C_we2", 128'(we2_c), 128'(e.a.we2));
                chk("C_wa2", 128'(wa2_c), 128'(e.a.wa2));
                chk("C_wd2", wd2_c, e.a.wd2);
                // Known first batch for seed 1: w1=0x00042021, wa1 low chunk 0x04080601.
                if (e.tag == 1) begin
                    chk("first_we1", 128'(we1_a), 128'h1);
                    chk("first_we2", 128'(we2_a), 128'h0);
                    chk("first_wa1", 128'(wa1_a), 128'h1);
                    chk("first_wa2", 128'(wa2_a), 128'h0);
                    chk("first_wd2", wd2_a, 128'h0);
                end
            end
        end
    end

endmodule
`default_nettype wire
